fetch_decode_stage: RTL
=======================

# fetch_decode_stage

Instruction fetch and IF/ID pipeline stage for the LEGv8 datapath, sitting directly upstream of the immediate sign extender. Holds the program counter, drives the instruction-memory address, registers the fetched word with its PC, and decodes the registered instruction into the sign extender's inputs: 26-bit immediate field, 3-bit format select, 2-bit MOVZ shift. Supports stall, flush and taken-branch redirect from later stages.

## Interface
Parameters:
- RESET_PC, 64'h0: PC value loaded on reset.

Ports:
- CLK  in  1  rising-edge clock.
- resetl  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and IF/ID contents this cycle.
- flush  in  1  replace IF/ID contents with a bubble this cycle.
- branch_taken  in  1  redirect PC to branch_target.
- branch_target  in  64  redirect address; bits [1:0] forced to 0 on load.
- InstrAddr  out  64  current PC to instruction memory (= PC register).
- Instr  in  32  instruction word for InstrAddr, valid in the same cycle (combinational memory).
- id_valid  out  1  IF/ID holds a real instruction.
- id_pc  out  64  PC of the IF/ID instruction.
- id_instr  out  32  registered instruction word.
- Imm26  out  26  id_instr[25:0].
- ShiftBits  out  2  id_instr[22:21].
- SignOp  out  3  immediate-format select for the sign extender.
- imm_used  out  1  id_instr is a recognised immediate-carrying opcode and id_valid=1.

## Operation
- PC register, next-state priority:
  - branch_taken=1: {branch_target[63:2],2'b00}, regardless of stall.
  - else stall=1: hold.
  - else PC+4, 64-bit wrap (FFFF_FFFF_FFFF_FFFC -> 0).
- IF/ID register (id_valid, id_pc, id_instr), priority:
  - flush=1: bubble (id_valid=0, id_pc=0, id_instr=0).
  - else stall=1: hold.
  - else capture {1, PC, Instr}.
- branch_taken without flush is legal. The wrong-path word is captured; squashing it is the caller's job.
- SignOp/imm_used decode is combinational from registered id_instr, checked in this order:
  - [31:26]=000101 (B) or 100101 (BL): SignOp 010.
  - [31:24]=10110100 (CBZ) or 10110101 (CBNZ): SignOp 011.
  - [31:21]=11111000010 (LDUR) or 11111000000 (STUR): SignOp 001.
  - [31:23]=110100101 (MOVZ): SignOp 100.
  - [31:22] in {1001000100 ADDI, 1011000100 ADDIS, 1101000100 SUBI, 1111000100 SUBIS, 1001001000 ANDI, 1011001000 ORRI, 1101001000 EORI, 1111001000 ANDIS}: SignOp 000.
  - anything else: SignOp 000, imm_used 0.
- imm_used=1 only for a matched opcode with id_valid=1. A bubble always gives imm_used=0, SignOp=000.
- Imm26 and ShiftBits are raw slices and pass through unchanged for every instruction.

## Timing
- resetl low, asynchronous and immediate:
  - PC=RESET_PC, so InstrAddr=RESET_PC.
  - id_valid=0, id_pc=0, id_instr=0.
  - Derived outputs: Imm26=0, ShiftBits=0, SignOp=000, imm_used=0.
- First rising edge after resetl deasserts: captures the word at RESET_PC. id_valid=1 from that edge on. PC becomes RESET_PC+4.
- Latency: one cycle from InstrAddr/Instr to id_* and the decode outputs. Decode outputs settle combinationally after the edge.
- Redirect: branch_taken sampled at edge N gives InstrAddr=target after edge N. The target instruction appears in IF/ID after edge N+1.
- stall and flush together: flush wins for IF/ID, PC holds unless branch_taken.
- Reset asserted mid-stream discards all state. No partial update on the reset edge.

## Test plan
- Reset/sequence: RESET_PC=0, memory returns 32'h91000421 (ADDI) at 0. After reset, InstrAddr=0. After 1st edge: id_valid=1, id_pc=0, SignOp=000, imm_used=1, Imm26=26'h1000421, InstrAddr=4.
- Decode sweep, one word per cycle, each -> SignOp/imm_used:
  - 0x14000010 (B) -> 010/1.
  - 0xB4000041 (CBZ) -> 011/1.
  - 0xF8408020 (LDUR) -> 001/1.
  - 0xD2A00020 (MOVZ, hw=01) -> 100/1, ShiftBits=01.
  - 0x8B020020 (ADD) -> 000/0.
- Stall: stall=1 for 3 cycles at PC=8 -> InstrAddr stays 8 and id_* hold. Release -> id_pc=8 next edge.
- Branch + flush: branch_taken=1, flush=1, branch_target=0x103 at PC=0x10:
  - next edge: InstrAddr=0x100, id_valid=0, imm_used=0.
  - following edge: id_pc=0x100.
- Priority: stall=1, flush=1, branch_taken=1 together -> PC loads target, IF/ID bubbles. Then PC wrap: PC=0xFFFF_FFFF_FFFF_FFFC -> next InstrAddr=0.
- Async reset mid-run: drop resetl between edges -> InstrAddr=RESET_PC and id_valid=0 immediately, before any clock edge.

Source files
------------

// File: rtl/fetch_decode_stage.sv
// LEGv8 instruction fetch with IF/ID pipeline register.
// Also decodes the registered word into the immediate sign extender's controls.
module fetch_decode_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] InstrAddr,
  input  logic [31:0] Instr,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_instr,
  output logic [25:0] Imm26,
  output logic [1:0]  ShiftBits,
  output logic [2:0]  SignOp,
  output logic        imm_used
);

  localparam logic [2:0] SIGN_I  = 3'b000;
  localparam logic [2:0] SIGN_D  = 3'b001;
  localparam logic [2:0] SIGN_B  = 3'b010;
  localparam logic [2:0] SIGN_CB = 3'b011;
  localparam logic [2:0] SIGN_IW = 3'b100;

  logic [63:0] pc;
  logic [63:0] pc_next;
  logic [63:0] target_aligned;

  assign target_aligned = branch_target & ~64'h3;

  // Redirect beats stall so a taken branch is never lost behind a hazard.
  always_comb begin
    pc_next = pc + 64'd4;
    if (branch_taken) begin
      pc_next = target_aligned;
    end else if (stall) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  assign InstrAddr = pc;

  // Flush beats stall: a squashed slot must not linger while the pipe is held.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      id_valid <= 1'b0;
      id_pc    <= 64'h0;
      id_instr <= 32'h0;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_pc    <= 64'h0;
      id_instr <= 32'h0;
    end else if (!stall) begin
      id_valid <= 1'b1;
      id_pc    <= pc;
      id_instr <= Instr;
    end
  end

  assign Imm26     = id_instr[25:0];
  assign ShiftBits = id_instr[22:21];

  logic [2:0] dec_sign;
  logic       dec_match;

  always_comb begin
    dec_sign  = SIGN_I;
    dec_match = 1'b0;
    if (id_instr[31:26] == 6'b000101 || id_instr[31:26] == 6'b100101) begin
      dec_sign  = SIGN_B;
      dec_match = 1'b1;
    end else if (id_instr[31:24] == 8'b10110100 || id_instr[31:24] == 8'b10110101) begin
      dec_sign  = SIGN_CB;
      dec_match = 1'b1;
    end else if (id_instr[31:21] == 11'b11111000010 || id_instr[31:21] == 11'b11111000000) begin
      dec_sign  = SIGN_D;
      dec_match = 1'b1;
    end else if (id_instr[31:23] == 9'b110100101) begin
      dec_sign  = SIGN_IW;
      dec_match = 1'b1;
    end else begin
      case (id_instr[31:22])
        10'b1001000100, 10'b1011000100, 10'b1101000100, 10'b1111000100,
        10'b1001001000, 10'b1011001000, 10'b1101001000, 10'b1111001000: begin
          dec_sign  = SIGN_I;
          dec_match = 1'b1;
        end
        default: begin
          dec_sign  = SIGN_I;
          dec_match = 1'b0;
        end
      endcase
    end
  end

  assign SignOp   = id_valid ? dec_sign : SIGN_I;
  assign imm_used = id_valid & dec_match;

endmodule
